// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, load/store funct3
// encodings, result-source select and access-size decode.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RSP  = 2'd2
    } mem_fsm_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } acc_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // Undefined size encodings fall back to a word access.
    function automatic acc_size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// load byte/half extraction with sign or zero extension, and misalignment.
import mem_access_stage_pkg::*;

module load_store_align (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_read_data,
    output logic        o_misaligned
);

    acc_size_e   w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_size = access_size(i_funct3);
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_store_data;
        o_read_data  = i_rdata;
        o_misaligned = 1'b0;
        case (w_size)
            SIZE_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_read_data = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_store_data[15:0]}};
                o_read_data  = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: drives the req/gnt/rvalid data bus, stalls upstream while
// an access is outstanding, and holds the MEM/WB pipeline register.
import mem_access_stage_pkg::*;

module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_m_i,
    input  logic                      reg_write_m_i,
    input  logic [1:0]                result_src_m_i,
    input  logic                      mem_write_m_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_m_i,
    input  logic [DATA_WIDTH-1:0]     write_data_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus_4_m_i,
    input  logic [2:0]                funct3_m_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [DATA_WIDTH-1:0]     dmem_addr_o,
    output logic [3:0]                dmem_be_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      stall_m_o,
    output logic                      valid_w_o,
    output logic                      reg_write_w_o,
    output logic [1:0]                result_src_w_o,
    output logic [DATA_WIDTH-1:0]     alu_result_w_o,
    output logic [DATA_WIDTH-1:0]     read_data_w_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_w_o,
    output logic [DATA_WIDTH-1:0]     pc_plus_4_w_o,
    output logic                      misaligned_w_o
);

    mem_fsm_e                  r_state;
    logic                      r_valid_w;
    logic                      r_reg_write_w;
    logic [1:0]                r_result_src_w;
    logic [DATA_WIDTH-1:0]     r_alu_result_w;
    logic [DATA_WIDTH-1:0]     r_read_data_w;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr_w;
    logic [DATA_WIDTH-1:0]     r_pc_plus_4_w;
    logic                      r_misaligned_w;

    logic                      w_access;
    logic                      w_misaligned;
    logic                      w_req;
    logic                      w_rsp_done;
    logic                      w_stall;
    logic [DATA_WIDTH-1:0]     w_read_data;

    load_store_align u_align (
        .i_funct3     (funct3_m_i),
        .i_addr_lo    (alu_result_m_i[1:0]),
        .i_store_data (write_data_m_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (dmem_be_o),
        .o_wdata      (dmem_wdata_o),
        .o_read_data  (w_read_data),
        .o_misaligned (w_misaligned)
    );

    assign w_access   = valid_m_i & (mem_write_m_i | (result_src_m_i == RES_LOAD));
    assign w_rsp_done = (r_state == MEM_RSP) & dmem_rvalid_i;
    // Bus outputs come straight from EX/MEM; upstream holds them stable while stalled.
    assign w_req      = ((r_state == MEM_IDLE) & w_access & ~w_misaligned) | (r_state == MEM_REQ);
    assign w_stall    = w_access & ~w_misaligned & ~w_rsp_done;

    assign dmem_req_o   = w_req;
    assign dmem_we_o    = mem_write_m_i;
    assign dmem_addr_o  = {alu_result_m_i[DATA_WIDTH-1:2], 2'b00};
    assign stall_m_o    = w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= MEM_IDLE;
            r_valid_w      <= 1'b0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= '0;
            r_alu_result_w <= '0;
            r_read_data_w  <= '0;
            r_rd_addr_w    <= '0;
            r_pc_plus_4_w  <= '0;
            r_misaligned_w <= 1'b0;
        end else begin
            case (r_state)
                MEM_IDLE: if (w_req) r_state <= dmem_gnt_i ? MEM_RSP : MEM_REQ;
                MEM_REQ:  if (dmem_gnt_i) r_state <= MEM_RSP;
                MEM_RSP:  if (dmem_rvalid_i) r_state <= MEM_IDLE;
                default:  r_state <= MEM_IDLE;
            endcase

            if (w_stall) begin
                r_valid_w      <= 1'b0;
                r_reg_write_w  <= 1'b0;
                r_misaligned_w <= 1'b0;
            end else begin
                r_valid_w      <= valid_m_i;
                r_reg_write_w  <= valid_m_i & reg_write_m_i & ~(w_access & w_misaligned);
                r_misaligned_w <= w_access & w_misaligned;
                r_result_src_w <= result_src_m_i;
                r_alu_result_w <= alu_result_m_i;
                r_rd_addr_w    <= rd_addr_m_i;
                r_pc_plus_4_w  <= pc_plus_4_m_i;
                if (w_rsp_done) r_read_data_w <= w_read_data;
            end
        end
    end

    assign valid_w_o      = r_valid_w;
    assign reg_write_w_o  = r_reg_write_w;
    assign result_src_w_o = r_result_src_w;
    assign alu_result_w_o = r_alu_result_w;
    assign read_data_w_o  = r_read_data_w;
    assign rd_addr_w_o    = r_rd_addr_w;
    assign pc_plus_4_w_o  = r_pc_plus_4_w;
    assign misaligned_w_o = r_misaligned_w;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores with a
// withheld grant, misaligned access and reset in the middle of a load.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_m_i = 1'b0;
    logic        reg_write_m_i = 1'b0;
    logic [1:0]  result_src_m_i = 2'b00;
    logic        mem_write_m_i = 1'b0;
    logic [31:0] alu_result_m_i = '0;
    logic [31:0] write_data_m_i = '0;
    logic [4:0]  rd_addr_m_i = '0;
    logic [31:0] pc_plus_4_m_i = '0;
    logic [2:0]  funct3_m_i = '0;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    logic        dmem_req_o, dmem_we_o, stall_m_o, valid_w_o, reg_write_w_o, misaligned_w_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, alu_result_w_o, read_data_w_o, pc_plus_4_w_o;
    logic [3:0]  dmem_be_o;
    logic [1:0]  result_src_w_o;
    logic [4:0]  rd_addr_w_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .valid_m_i(valid_m_i), .reg_write_m_i(reg_write_m_i), .result_src_m_i(result_src_m_i),
        .mem_write_m_i(mem_write_m_i), .alu_result_m_i(alu_result_m_i), .write_data_m_i(write_data_m_i),
        .rd_addr_m_i(rd_addr_m_i), .pc_plus_4_m_i(pc_plus_4_m_i), .funct3_m_i(funct3_m_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_m_o(stall_m_o), .valid_w_o(valid_w_o), .reg_write_w_o(reg_write_w_o),
        .result_src_w_o(result_src_w_o), .alu_result_w_o(alu_result_w_o), .read_data_w_o(read_data_w_o),
        .rd_addr_w_o(rd_addr_w_o), .pc_plus_4_w_o(pc_plus_4_w_o), .misaligned_w_o(misaligned_w_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic [1:0] rsrc, input logic mw,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                             input logic [31:0] pc4, input logic [2:0] f3);
        valid_m_i      = v;
        reg_write_m_i  = rw;
        result_src_m_i = rsrc;
        mem_write_m_i  = mw;
        alu_result_m_i = alu;
        write_data_m_i = wd;
        rd_addr_m_i    = rd;
        pc_plus_4_m_i  = pc4;
        funct3_m_i     = f3;
    endtask

    // Load with grant in cycle 0 and rvalid in cycle 1.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        set_instr(1'b1, 1'b1, 2'b01, 1'b0, addr, 32'h0, 5'd3, 32'h204, f3);
        dmem_gnt_i = 1'b1;
        #2;
        chk({tag, ".stall0"}, stall_m_o, 1);
        chk({tag, ".req0"}, dmem_req_o, 1);
        chk({tag, ".addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        tick;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        chk({tag, ".bubble"}, valid_w_o, 0);
        #2;
        chk({tag, ".stall1"}, stall_m_o, 0);
        chk({tag, ".req1"}, dmem_req_o, 0);
        tick;
        dmem_rvalid_i = 1'b0;
        chk({tag, ".valid_w"}, valid_w_o, 1);
        chk({tag, ".reg_write_w"}, reg_write_w_o, 1);
        chk({tag, ".read_data"}, read_data_w_o, exp);
    endtask

    initial begin
        #1;
        chk("rst.valid_w", valid_w_o, 0);
        chk("rst.req", dmem_req_o, 0);
        chk("rst.stall", stall_m_o, 0);
        chk("rst.read_data", read_data_w_o, 0);
        tick;
        tick;
        rst = 1'b0;

        // ALU op passes straight through
        set_instr(1'b1, 1'b1, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd9, 32'h88, 3'b000);
        #2;
        chk("alu.req", dmem_req_o, 0);
        chk("alu.stall", stall_m_o, 0);
        tick;
        chk("alu.valid_w", valid_w_o, 1);
        chk("alu.result", alu_result_w_o, 32'h1234);
        chk("alu.rd", rd_addr_w_o, 9);
        chk("alu.pc4", pc_plus_4_w_o, 32'h88);
        chk("alu.reg_write", reg_write_w_o, 1);

        do_load("lw",  3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb",  3'b000, 32'h103, 32'h80FFFF7F, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80FFFF7F, 32'h00000080);
        do_load("lh",  3'b001, 32'h102, 32'h80FFFF7F, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h102, 32'h80FFFF7F, 32'h000080FF);

        // SH with grant withheld 3 cycles and a spurious rvalid while waiting
        set_instr(1'b1, 1'b0, 2'b00, 1'b1, 32'h202, 32'h0000ABCD, 5'd0, 32'h0, 3'b001);
        for (int i = 0; i < 3; i++) begin
            dmem_rvalid_i = (i == 1);
            #2;
            chk("sh.req_wait", dmem_req_o, 1);
            chk("sh.we", dmem_we_o, 1);
            chk("sh.addr", dmem_addr_o, 32'h200);
            chk("sh.be", dmem_be_o, 4'b1100);
            chk("sh.wdata", dmem_wdata_o, 32'hABCDABCD);
            chk("sh.stall_wait", stall_m_o, 1);
            tick;
            chk("sh.bubble", valid_w_o, 0);
        end
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b1;
        #2;
        chk("sh.req_gnt", dmem_req_o, 1);
        chk("sh.stall_gnt", stall_m_o, 1);
        tick;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        #2;
        chk("sh.req_rsp", dmem_req_o, 0);
        chk("sh.stall_rsp", stall_m_o, 0);
        tick;
        dmem_rvalid_i = 1'b0;
        chk("sh.valid_w", valid_w_o, 1);
        chk("sh.reg_write_w", reg_write_w_o, 0);

        // SB lane steering
        set_instr(1'b1, 1'b0, 2'b00, 1'b1, 32'h201, 32'h1234565A, 5'd0, 32'h0, 3'b000);
        #2;
        chk("sb.be", dmem_be_o, 4'b0010);
        chk("sb.wdata", dmem_wdata_o, 32'h5A5A5A5A);

        // misaligned LW: no request, completes in one cycle
        set_instr(1'b1, 1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 5'd4, 32'h0, 3'b010);
        #1;
        chk("mis.req", dmem_req_o, 0);
        chk("mis.stall", stall_m_o, 0);
        tick;
        chk("mis.flag", misaligned_w_o, 1);
        chk("mis.reg_write", reg_write_w_o, 0);
        chk("mis.valid_w", valid_w_o, 1);
        set_instr(1'b1, 1'b1, 2'b00, 1'b0, 32'h777, 32'h0, 5'd7, 32'h44, 3'b000);
        tick;
        chk("mis.flag_clr", misaligned_w_o, 0);
        chk("mis.next_alu", alu_result_w_o, 32'h777);

        // reset while waiting for rvalid
        set_instr(1'b1, 1'b1, 2'b01, 1'b0, 32'h300, 32'h0, 5'd5, 32'h0, 3'b010);
        dmem_gnt_i = 1'b1;
        tick;
        dmem_gnt_i = 1'b0;
        chk("rstm.held_alu", alu_result_w_o, 32'h777);
        #2;
        rst       = 1'b1;
        valid_m_i = 1'b0;
        #1;
        chk("rstm.alu", alu_result_w_o, 0);
        chk("rstm.pc4", pc_plus_4_w_o, 0);
        chk("rstm.read_data", read_data_w_o, 0);
        chk("rstm.req", dmem_req_o, 0);
        chk("rstm.stall", stall_m_o, 0);
        tick;
        rst           = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h55555555;
        tick;
        dmem_rvalid_i = 1'b0;
        chk("rstm.late_rvalid", read_data_w_o, 0);
        chk("rstm.valid_w", valid_w_o, 0);
        set_instr(1'b1, 1'b1, 2'b00, 1'b0, 32'hABC, 32'h0, 5'd1, 32'h10, 3'b000);
        #1;
        chk("rstm.alu_stall", stall_m_o, 0);
        tick;
        chk("rstm.alu_valid", valid_w_o, 1);
        chk("rstm.alu_result", alu_result_w_o, 32'hABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
